// File: rtl/bp_gshare_spec_if.sv
// Bundle between the fetch/backend side and the gshare branch predictor.
//
// Signal groups:
//   flush                      full pipeline flush (exception / fence)
//   fetch_*                    per-cycle prediction query
//   pred_*                     combinational prediction and checkpoint
//                              (GHR and RAS pointer as seen before this query)
//   redirect_*                 mispredict recovery, carrying the checkpoint
//                              of the mispredicted branch
//   upd_*                      NUM_UPD in-order training ports, flattened;
//                              port k occupies slice [k*W +: W]
//
// Handshake: no backpressure anywhere. A query, redirect or training port
// takes effect in any cycle its valid bit is high; the predictor is always
// ready, and prediction outputs are valid in the same cycle as fetch_valid.
//
// Modports: master = frontend/backend driver, slave = predictor.

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

interface bp_gshare_spec_if #(
  parameter int ADDR_W    = `INST_ADDR_WIDTH,
  parameter int GHR_BITS  = 8,
  parameter int RAS_DEPTH = 8,
  parameter int NUM_UPD   = 2
);
  localparam int SP_W = $clog2(RAS_DEPTH);

  logic                         flush;

  logic                         fetch_valid;
  logic [ADDR_W-1:0]            fetch_pc;
  logic                         pred_taken;
  logic [ADDR_W-1:0]            pred_target;
  logic [GHR_BITS-1:0]          pred_hist;
  logic [SP_W-1:0]              pred_ras_sp;

  logic                         redirect_valid;
  logic [ADDR_W-1:0]            redirect_pc;
  logic [GHR_BITS-1:0]          redirect_hist;
  logic [SP_W-1:0]              redirect_ras_sp;
  logic                         redirect_taken;
  logic                         redirect_is_cond;
  logic                         redirect_is_call;
  logic                         redirect_is_ret;

  logic [NUM_UPD-1:0]           upd_valid;
  logic [NUM_UPD*ADDR_W-1:0]    upd_pc;
  logic [NUM_UPD*ADDR_W-1:0]    upd_target;
  logic [NUM_UPD*GHR_BITS-1:0]  upd_hist;
  logic [NUM_UPD-1:0]           upd_taken;
  logic [NUM_UPD-1:0]           upd_is_cond;
  logic [NUM_UPD-1:0]           upd_is_call;
  logic [NUM_UPD-1:0]           upd_is_ret;

  modport master (
    output flush,
    output fetch_valid, fetch_pc,
    input  pred_taken, pred_target, pred_hist, pred_ras_sp,
    output redirect_valid, redirect_pc, redirect_hist, redirect_ras_sp,
    output redirect_taken, redirect_is_cond, redirect_is_call, redirect_is_ret,
    output upd_valid, upd_pc, upd_target, upd_hist,
    output upd_taken, upd_is_cond, upd_is_call, upd_is_ret
  );

  modport slave (
    input  flush,
    input  fetch_valid, fetch_pc,
    output pred_taken, pred_target, pred_hist, pred_ras_sp,
    input  redirect_valid, redirect_pc, redirect_hist, redirect_ras_sp,
    input  redirect_taken, redirect_is_cond, redirect_is_call, redirect_is_ret,
    input  upd_valid, upd_pc, upd_target, upd_hist,
    input  upd_taken, upd_is_cond, upd_is_call, upd_is_ret
  );
endinterface

// File: rtl/bp_gshare_spec.sv
// Gshare branch predictor for the fetch stage.
//
// A gshare PHT of 2-bit counters, a PC-indexed tagged BTB that records the
// branch kind (cond/call/ret), and a circular return-address stack. The
// global history and RAS pointer are advanced speculatively on every BTB hit
// at fetch, checkpointed on pred_hist / pred_ras_sp, and restored from that
// checkpoint on a redirect. PHT and BTB are trained by NUM_UPD in-order
// resolution ports.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bp     bp_gshare_spec_if.slave (flush, fetch query, prediction,
//          redirect, training ports)
//
// Priority of GHR/RAS updates: flush > redirect > fetch speculation.
// Training is independent of that priority and applies every cycle.

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 1
`endif
`ifndef INST_ADD_STEP
`define INST_ADD_STEP 4
`endif

module bp_gshare_spec #(
  parameter int ADDR_W       = `INST_ADDR_WIDTH,
  parameter int GHR_BITS     = 8,
  parameter int PHT_IDX_BITS = 8,
  parameter int BTB_IDX_BITS = 6,
  parameter int RAS_DEPTH    = 8,
  parameter int NUM_UPD      = 2,
  parameter int FETCH_STRIDE = `IF_BATCH_SIZE * `INST_ADD_STEP
) (
  input logic               clk,
  input logic               rst_n,
  bp_gshare_spec_if.slave   bp
);
  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int PHT_N = 1 << PHT_IDX_BITS;
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int TAG_W = ADDR_W - BTB_IDX_BITS - 2;
  // History is zero-extended when shorter than the PHT index.
  localparam int HX_W  = (GHR_BITS > PHT_IDX_BITS) ? GHR_BITS : PHT_IDX_BITS;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic              cond;
    logic              call;
    logic              ret;
  } btb_entry_t;

  function automatic logic [PHT_IDX_BITS-1:0] pht_index(
    input logic [GHR_BITS-1:0] hist,
    input logic [ADDR_W-1:0]   pc
  );
    logic [HX_W-1:0] hx;
    hx = HX_W'(hist);
    return hx[PHT_IDX_BITS-1:0] ^ pc[PHT_IDX_BITS+1:2];
  endfunction

  function automatic logic [BTB_IDX_BITS-1:0] btb_index(input logic [ADDR_W-1:0] pc);
    return pc[BTB_IDX_BITS+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] btb_tag(input logic [ADDR_W-1:0] pc);
    return pc[ADDR_W-1:BTB_IDX_BITS+2];
  endfunction

  // State
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [1:0]          pht_q [PHT_N];
  logic [1:0]          pht_d [PHT_N];
  btb_entry_t          btb_q [BTB_N];
  btb_entry_t          btb_d [BTB_N];
  logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0]   ras_d [RAS_DEPTH];

  // Lookup
  logic [PHT_IDX_BITS-1:0] f_pidx;
  btb_entry_t              f_entry;
  logic                    f_hit;
  logic                    f_ctr_taken;
  logic                    f_taken;
  logic [ADDR_W-1:0]       f_target;

  always_comb begin
    f_pidx      = pht_index(ghr_q, bp.fetch_pc);
    f_entry     = btb_q[btb_index(bp.fetch_pc)];
    f_hit       = f_entry.valid && (f_entry.tag == btb_tag(bp.fetch_pc));
    f_ctr_taken = pht_q[f_pidx][1];
    f_taken     = bp.fetch_valid && f_hit && (!f_entry.cond || f_ctr_taken);
    if (f_taken && f_entry.ret) begin
      f_target = ras_q[sp_q - SP_W'(1)];
    end else if (f_taken) begin
      f_target = f_entry.target;
    end else begin
      f_target = bp.fetch_pc + ADDR_W'(FETCH_STRIDE);
    end
  end

  assign bp.pred_taken  = f_taken;
  assign bp.pred_target = f_target;
  assign bp.pred_hist   = ghr_q;
  assign bp.pred_ras_sp = sp_q;

  // Speculative history / RAS
  // Speculation follows any BTB hit, taken or not: a conditional hit shifts
  // in the counter's prediction, which is what the backend later corrects.
  always_comb begin
    ghr_d = ghr_q;
    sp_d  = sp_q;
    ras_d = ras_q;
    if (bp.flush) begin
      ghr_d = '0;
      sp_d  = '0;
    end else if (bp.redirect_valid) begin
      ghr_d = bp.redirect_is_cond ?
              {bp.redirect_hist[GHR_BITS-2:0], bp.redirect_taken} : bp.redirect_hist;
      sp_d  = bp.redirect_ras_sp;
      if (bp.redirect_is_call) begin
        ras_d[bp.redirect_ras_sp] = bp.redirect_pc + ADDR_W'(4);
        sp_d = bp.redirect_ras_sp + SP_W'(1);
      end else if (bp.redirect_is_ret) begin
        sp_d = bp.redirect_ras_sp - SP_W'(1);
      end
    end else if (bp.fetch_valid && f_hit) begin
      if (f_entry.cond) begin
        ghr_d = {ghr_q[GHR_BITS-2:0], f_ctr_taken};
      end
      // Pointer wraps; overflow silently overwrites the oldest entry.
      if (f_entry.call) begin
        ras_d[sp_q] = bp.fetch_pc + ADDR_W'(4);
        sp_d = sp_q + SP_W'(1);
      end else if (f_entry.ret) begin
        sp_d = sp_q - SP_W'(1);
      end
    end
  end

  // Training
  // Ports are folded in order on top of the running next-state copy, so two
  // ports on one counter accumulate and the last port wins a BTB collision.
  always_comb begin
    pht_d = pht_q;
    btb_d = btb_q;
    for (int k = 0; k < NUM_UPD; k++) begin
      if (bp.upd_valid[k] && bp.upd_is_cond[k]) begin
        if (bp.upd_taken[k]) begin
          if (pht_d[pht_index(bp.upd_hist[k*GHR_BITS +: GHR_BITS],
                              bp.upd_pc[k*ADDR_W +: ADDR_W])] != 2'b11) begin
            pht_d[pht_index(bp.upd_hist[k*GHR_BITS +: GHR_BITS], bp.upd_pc[k*ADDR_W +: ADDR_W])] =
              pht_d[pht_index(bp.upd_hist[k*GHR_BITS +: GHR_BITS], bp.upd_pc[k*ADDR_W +: ADDR_W])] + 2'd1;
          end
        end else begin
          if (pht_d[pht_index(bp.upd_hist[k*GHR_BITS +: GHR_BITS],
                              bp.upd_pc[k*ADDR_W +: ADDR_W])] != 2'b00) begin
            pht_d[pht_index(bp.upd_hist[k*GHR_BITS +: GHR_BITS], bp.upd_pc[k*ADDR_W +: ADDR_W])] =
              pht_d[pht_index(bp.upd_hist[k*GHR_BITS +: GHR_BITS], bp.upd_pc[k*ADDR_W +: ADDR_W])] - 2'd1;
          end
        end
      end
      if (bp.upd_valid[k] && bp.upd_taken[k]) begin
        btb_d[btb_index(bp.upd_pc[k*ADDR_W +: ADDR_W])].valid  = 1'b1;
        btb_d[btb_index(bp.upd_pc[k*ADDR_W +: ADDR_W])].tag    = btb_tag(bp.upd_pc[k*ADDR_W +: ADDR_W]);
        btb_d[btb_index(bp.upd_pc[k*ADDR_W +: ADDR_W])].target = bp.upd_target[k*ADDR_W +: ADDR_W];
        btb_d[btb_index(bp.upd_pc[k*ADDR_W +: ADDR_W])].cond   = bp.upd_is_cond[k];
        btb_d[btb_index(bp.upd_pc[k*ADDR_W +: ADDR_W])].call   = bp.upd_is_call[k];
        btb_d[btb_index(bp.upd_pc[k*ADDR_W +: ADDR_W])].ret    = bp.upd_is_ret[k];
      end
    end
  end

  // Registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
      sp_q  <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      ghr_q <= ghr_d;
      sp_q  <= sp_d;
      pht_q <= pht_d;
      btb_q <= btb_d;
      ras_q <= ras_d;
    end
  end
endmodule

// File: tb/tb_bp_gshare_spec.sv
// Bench for bp_gshare_spec: directed scenarios plus randomized traffic
// against an arithmetic reference model of the predictor.
module tb_bp_gshare_spec;
  localparam int ADDR_W       = 32;
  localparam int GHR_BITS     = 8;
  localparam int PHT_IDX_BITS = 8;
  localparam int BTB_IDX_BITS = 6;
  localparam int RAS_DEPTH    = 8;
  localparam int NUM_UPD      = 2;
  localparam int FETCH_STRIDE = 4;
  localparam int PHT_N        = 1 << PHT_IDX_BITS;
  localparam int BTB_N        = 1 << BTB_IDX_BITS;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bp_gshare_spec_if #(.ADDR_W(ADDR_W), .GHR_BITS(GHR_BITS),
                      .RAS_DEPTH(RAS_DEPTH), .NUM_UPD(NUM_UPD)) bpi ();

  bp_gshare_spec #(
    .ADDR_W(ADDR_W), .GHR_BITS(GHR_BITS), .PHT_IDX_BITS(PHT_IDX_BITS),
    .BTB_IDX_BITS(BTB_IDX_BITS), .RAS_DEPTH(RAS_DEPTH), .NUM_UPD(NUM_UPD),
    .FETCH_STRIDE(FETCH_STRIDE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bp(bpi)
  );

  // Reference model (plain integers)
  int unsigned m_ghr, m_sp;
  int unsigned m_pht [PHT_N];
  bit          m_bv [BTB_N];
  int unsigned m_btag [BTB_N];
  int unsigned m_btgt [BTB_N];
  bit          m_bcond [BTB_N];
  bit          m_bcall [BTB_N];
  bit          m_bret [BTB_N];
  int unsigned m_ras [RAS_DEPTH];

  task automatic model_reset();
    m_ghr = 0;
    m_sp  = 0;
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    for (int i = 0; i < BTB_N; i++) m_bv[i] = 1'b0;
    for (int i = 0; i < RAS_DEPTH; i++) m_ras[i] = 0;
  endtask

  function automatic void model_predict(input bit fv, input int unsigned pc,
                                        output bit t, output int unsigned tgt);
    int unsigned b;
    bit hit, ctr;
    b   = (pc >> 2) % BTB_N;
    hit = m_bv[b] && (m_btag[b] == (pc >> (BTB_IDX_BITS + 2)));
    ctr = m_pht[(m_ghr ^ (pc >> 2)) % PHT_N] >= 2;
    t   = fv && hit && (!m_bcond[b] || ctr);
    if (t) tgt = m_bret[b] ? m_ras[(m_sp + RAS_DEPTH - 1) % RAS_DEPTH] : m_btgt[b];
    else   tgt = pc + FETCH_STRIDE;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_apply();
    int unsigned pc, b, rh, rsp, upc, uh, p, ub;
    bit hit, ctr;
    pc  = bpi.fetch_pc;
    b   = (pc >> 2) % BTB_N;
    hit = m_bv[b] && (m_btag[b] == (pc >> (BTB_IDX_BITS + 2)));
    ctr = m_pht[(m_ghr ^ (pc >> 2)) % PHT_N] >= 2;
    if (bpi.flush) begin
      m_ghr = 0;
      m_sp  = 0;
    end else if (bpi.redirect_valid) begin
      rh  = bpi.redirect_hist;
      rsp = bpi.redirect_ras_sp;
      m_ghr = bpi.redirect_is_cond ? ((rh * 2 + bpi.redirect_taken) % PHT_N) : rh;
      m_sp  = rsp;
      if (bpi.redirect_is_call) begin
        m_ras[rsp] = bpi.redirect_pc + 4;
        m_sp = (rsp + 1) % RAS_DEPTH;
      end else if (bpi.redirect_is_ret) begin
        m_sp = (rsp + RAS_DEPTH - 1) % RAS_DEPTH;
      end
    end else if (bpi.fetch_valid && hit) begin
      if (m_bcond[b]) m_ghr = (m_ghr * 2 + ctr) % PHT_N;
      if (m_bcall[b]) begin
        m_ras[m_sp] = pc + 4;
        m_sp = (m_sp + 1) % RAS_DEPTH;
      end else if (m_bret[b]) begin
        m_sp = (m_sp + RAS_DEPTH - 1) % RAS_DEPTH;
      end
    end
    for (int k = 0; k < NUM_UPD; k++) begin
      if (bpi.upd_valid[k]) begin
        upc = bpi.upd_pc[k*ADDR_W +: ADDR_W];
        uh  = bpi.upd_hist[k*GHR_BITS +: GHR_BITS];
        p   = (uh ^ (upc >> 2)) % PHT_N;
        ub  = (upc >> 2) % BTB_N;
        if (bpi.upd_is_cond[k]) begin
          if (bpi.upd_taken[k]) begin
            if (m_pht[p] < 3) m_pht[p] = m_pht[p] + 1;
          end else if (m_pht[p] > 0) begin
            m_pht[p] = m_pht[p] - 1;
          end
        end
        if (bpi.upd_taken[k]) begin
          m_bv[ub]    = 1'b1;
          m_btag[ub]  = upc >> (BTB_IDX_BITS + 2);
          m_btgt[ub]  = bpi.upd_target[k*ADDR_W +: ADDR_W];
          m_bcond[ub] = bpi.upd_is_cond[k];
          m_bcall[ub] = bpi.upd_is_call[k];
          m_bret[ub]  = bpi.upd_is_ret[k];
        end
      end
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    bpi.flush = 1'b0;
    bpi.fetch_valid = 1'b0;
    bpi.fetch_pc = '0;
    bpi.redirect_valid = 1'b0;
    bpi.redirect_pc = '0;
    bpi.redirect_hist = '0;
    bpi.redirect_ras_sp = '0;
    bpi.redirect_taken = 1'b0;
    bpi.redirect_is_cond = 1'b0;
    bpi.redirect_is_call = 1'b0;
    bpi.redirect_is_ret = 1'b0;
    bpi.upd_valid = '0;
    bpi.upd_pc = '0;
    bpi.upd_target = '0;
    bpi.upd_hist = '0;
    bpi.upd_taken = '0;
    bpi.upd_is_cond = '0;
    bpi.upd_is_call = '0;
    bpi.upd_is_ret = '0;
  endtask

  task automatic train(input int p, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [7:0] hist, input bit taken, input bit cond,
                       input bit call, input bit ret);
    bpi.upd_valid[p] = 1'b1;
    bpi.upd_pc[p*ADDR_W +: ADDR_W] = pc;
    bpi.upd_target[p*ADDR_W +: ADDR_W] = tgt;
    bpi.upd_hist[p*GHR_BITS +: GHR_BITS] = hist;
    bpi.upd_taken[p] = taken;
    bpi.upd_is_cond[p] = cond;
    bpi.upd_is_call[p] = call;
    bpi.upd_is_ret[p] = ret;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bpi.fetch_valid = 1'b1;
    bpi.fetch_pc = pc;
  endtask

  // Inputs are set just after a negedge; tick consumes them on the posedge.
  task automatic tick();
    @(posedge clk);
    model_apply();
    @(negedge clk);
  endtask

  // Tests
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fetch(32'h100);
    #1;
    checks++;
    if (bpi.pred_taken !== 1'b0 || bpi.pred_target !== 32'h104) begin
      errors++;
      $display("FAIL reset_pred taken=%0b target=%h expected taken=0 target=104",
               bpi.pred_taken, bpi.pred_target);
    end
    checks++;
    if (bpi.pred_hist !== 8'h00 || bpi.pred_ras_sp !== 3'd0) begin
      errors++;
      $display("FAIL reset_ckpt hist=%h sp=%0d expected hist=00 sp=0", bpi.pred_hist, bpi.pred_ras_sp);
    end
    // Reset asserted mid-cycle must win over a pending training write.
    @(negedge clk);
    train(0, 32'h200, 32'h300, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    fetch(32'h200);
    #1;
    checks++;
    if (bpi.pred_taken !== 1'b0 || bpi.pred_target !== 32'h204) begin
      errors++;
      $display("FAIL reset_overrides_train taken=%0b target=%h expected taken=0 target=204",
               bpi.pred_taken, bpi.pred_target);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_cond_learning();
    clear_inputs();
    train(0, 32'h200, 32'h300, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    clear_inputs();
    fetch(32'h200);
    #1;
    checks++;
    if (bpi.pred_taken !== 1'b1 || bpi.pred_target !== 32'h300 || bpi.pred_hist !== 8'h00) begin
      errors++;
      $display("FAIL cond_pred taken=%0b target=%h hist=%h expected taken=1 target=300 hist=00",
               bpi.pred_taken, bpi.pred_target, bpi.pred_hist);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bpi.pred_hist !== 8'h01) begin
      errors++;
      $display("FAIL cond_ghr_shift hist=%h expected 01", bpi.pred_hist);
    end
    tick();
  endtask

  task automatic test_call_ret();
    clear_inputs();
    bpi.flush = 1'b1;
    train(0, 32'h400, 32'h800, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    train(1, 32'h810, 32'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    fetch(32'h400);
    #1;
    checks++;
    if (bpi.pred_taken !== 1'b1 || bpi.pred_target !== 32'h800 || bpi.pred_ras_sp !== 3'd0) begin
      errors++;
      $display("FAIL call_pred taken=%0b target=%h sp=%0d expected taken=1 target=800 sp=0",
               bpi.pred_taken, bpi.pred_target, bpi.pred_ras_sp);
    end
    tick();
    clear_inputs();
    fetch(32'h810);
    #1;
    checks++;
    if (bpi.pred_taken !== 1'b1 || bpi.pred_target !== 32'h404 || bpi.pred_ras_sp !== 3'd1) begin
      errors++;
      $display("FAIL ret_pred taken=%0b target=%h sp=%0d expected taken=1 target=404 sp=1",
               bpi.pred_taken, bpi.pred_target, bpi.pred_ras_sp);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bpi.pred_ras_sp !== 3'd0) begin
      errors++;
      $display("FAIL ret_pop sp=%0d expected 0", bpi.pred_ras_sp);
    end
    tick();
  endtask

  task automatic test_redirect();
    logic [7:0] e;
    clear_inputs();
    bpi.flush = 1'b1;
    train(0, 32'h200, 32'h300, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    train(1, 32'h200, 32'h300, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    e = 8'h00;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      fetch(32'h200);
      #1;
      checks++;
      if (bpi.pred_hist !== e || bpi.pred_taken !== 1'b1) begin
        errors++;
        $display("FAIL spec_cond_%0d hist=%h taken=%0b expected hist=%h taken=1",
                 i, bpi.pred_hist, bpi.pred_taken, e);
      end
      tick();
      e = {e[6:0], 1'b1};
    end
    clear_inputs();
    #1;
    checks++;
    if (bpi.pred_hist !== 8'h07) begin
      errors++;
      $display("FAIL spec_ghr hist=%h expected 07", bpi.pred_hist);
    end
    // Redirect with a competing fetch in the same cycle.
    bpi.redirect_valid = 1'b1;
    bpi.redirect_pc = 32'h200;
    bpi.redirect_hist = 8'h01;
    bpi.redirect_ras_sp = 3'd2;
    bpi.redirect_taken = 1'b0;
    bpi.redirect_is_cond = 1'b1;
    fetch(32'h200);
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bpi.pred_hist !== 8'h02 || bpi.pred_ras_sp !== 3'd2) begin
      errors++;
      $display("FAIL redirect_restore hist=%h sp=%0d expected hist=02 sp=2",
               bpi.pred_hist, bpi.pred_ras_sp);
    end
    tick();
  endtask

  task automatic test_port_collision();
    clear_inputs();
    bpi.flush = 1'b1;
    train(0, 32'h1F0, 32'h1000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    train(1, 32'h1F0, 32'h2000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    // One not-taken: an accumulated 11 drops to 10 and still predicts taken.
    clear_inputs();
    train(0, 32'h1F0, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    fetch(32'h1F0);
    #1;
    checks++;
    if (bpi.pred_taken !== 1'b1 || bpi.pred_target !== 32'h2000) begin
      errors++;
      $display("FAIL collision_pred taken=%0b target=%h expected taken=1 target=2000",
               bpi.pred_taken, bpi.pred_target);
    end
    tick();
    clear_inputs();
    bpi.flush = 1'b1;
    train(0, 32'h1F0, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    fetch(32'h1F0);
    #1;
    checks++;
    if (bpi.pred_taken !== 1'b0 || bpi.pred_target !== 32'h1F4) begin
      errors++;
      $display("FAIL collision_decay taken=%0b target=%h expected taken=0 target=1f4",
               bpi.pred_taken, bpi.pred_target);
    end
    tick();
  endtask

  task automatic test_ras_wrap_flush();
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      bpi.flush = 1'b1;
      train(0, 32'h400 + 32'(8*k), 32'h800, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      if (k == 4) train(1, 32'h8A0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      else        train(1, 32'h404 + 32'(8*k), 32'h800, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k <= RAS_DEPTH; k++) begin
      clear_inputs();
      fetch(32'h400 + 32'(4*k));
      #1;
      checks++;
      if (bpi.pred_ras_sp !== 3'(k % RAS_DEPTH) || bpi.pred_taken !== 1'b1 ||
          bpi.pred_target !== 32'h800) begin
        errors++;
        $display("FAIL ras_push_%0d sp=%0d taken=%0b target=%h expected sp=%0d taken=1 target=800",
                 k, bpi.pred_ras_sp, bpi.pred_taken, bpi.pred_target, k % RAS_DEPTH);
      end
      tick();
    end
    clear_inputs();
    fetch(32'h8A0);
    #1;
    checks++;
    if (bpi.pred_ras_sp !== 3'd1 || bpi.pred_taken !== 1'b1 || bpi.pred_target !== 32'h424) begin
      errors++;
      $display("FAIL ras_wrap sp=%0d taken=%0b target=%h expected sp=1 taken=1 target=424",
               bpi.pred_ras_sp, bpi.pred_taken, bpi.pred_target);
    end
    // Flush beats the call fetch presented alongside it.
    fetch(32'h400);
    bpi.flush = 1'b1;
    tick();
    clear_inputs();
    fetch(32'h400);
    #1;
    checks++;
    if (bpi.pred_ras_sp !== 3'd0 || bpi.pred_hist !== 8'h00 || bpi.pred_taken !== 1'b1 ||
        bpi.pred_target !== 32'h800) begin
      errors++;
      $display("FAIL flush_state sp=%0d hist=%h taken=%0b target=%h expected sp=0 hist=00 taken=1 target=800",
               bpi.pred_ras_sp, bpi.pred_hist, bpi.pred_taken, bpi.pred_target);
    end
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 1) ? 32'h2000 : 32'h6000) + 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic test_random();
    bit et;
    int unsigned etgt;
    int t;
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      bpi.fetch_valid = ($urandom_range(0, 3) != 0);
      bpi.fetch_pc = rand_pc();
      for (int k = 0; k < NUM_UPD; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          t = $urandom_range(0, 3);
          train(k, rand_pc(), 32'h3000 + 32'(4 * $urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                t == 1, t == 2, t == 3);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        t = $urandom_range(0, 3);
        bpi.redirect_valid = 1'b1;
        bpi.redirect_pc = rand_pc();
        bpi.redirect_hist = 8'($urandom_range(0, 255));
        bpi.redirect_ras_sp = 3'($urandom_range(0, RAS_DEPTH - 1));
        bpi.redirect_taken = 1'($urandom_range(0, 1));
        bpi.redirect_is_cond = (t == 1);
        bpi.redirect_is_call = (t == 2);
        bpi.redirect_is_ret = (t == 3);
      end
      bpi.flush = ($urandom_range(0, 39) == 0);
      #1;
      model_predict(bpi.fetch_valid, bpi.fetch_pc, et, etgt);
      checks++;
      if (bpi.pred_taken !== et || bpi.pred_target !== ADDR_W'(etgt) ||
          bpi.pred_hist !== GHR_BITS'(m_ghr) || bpi.pred_ras_sp !== 3'(m_sp)) begin
        errors++;
        $display("FAIL random_%0d pc=%h taken=%0b target=%h hist=%h sp=%0d expected taken=%0b target=%h hist=%h sp=%0d",
                 n, bpi.fetch_pc, bpi.pred_taken, bpi.pred_target, bpi.pred_hist, bpi.pred_ras_sp,
                 et, etgt, m_ghr, m_sp);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cond_learning();
    test_call_ret();
    test_redirect();
    test_port_collision();
    test_ras_wrap_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
